// File: rtl/loopyV_data_types.sv
// Shared encodings for the loopyV pipeline: write-back source select,
// load funct3 codes and the width-independent MEM/WB control bundle.
package loopyV_data_types;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Control half of the MEM/WB register; the stage wraps it together with
  // its XLEN/REG_ADDR_W-sized payload fields.
  typedef struct packed {
    logic       valid;
    logic       rd_we;
    wb_sel_e    dest_sel;
    logic [2:0] funct3;
  } memwb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// Load alignment: picks the byte/halfword addressed by addr[1:0], extends it
// to XLEN and flags accesses that are misaligned for their size.
module load_align
  import loopyV_data_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    data       = '0;
    misaligned = 1'b0;

    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];

    case (funct3)
      LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      LW: begin
        data       = word;
        misaligned = (addr != 2'd0);
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back source selection, load alignment
// and an optional hold register that keeps load data stable across stalls.
module mem_wb_stage
  import loopyV_data_types::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter bit LOAD_HOLD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validMEM,
  input  logic                  stallWB,
  input  logic                  flushWB,
  input  logic [REG_ADDR_W-1:0] rdAddrMEM,
  input  logic                  rdWriteEnMEM,
  input  logic [1:0]            destinationSelectMEM,
  input  logic [XLEN-1:0]       pcMEM,
  input  logic [XLEN-1:0]       rdWriteDataMEM,
  input  logic [XLEN-1:0]       dmAddrMEM,
  input  logic [2:0]            loadStoreByteSelectMEM,
  input  logic [XLEN-1:0]       dmLoadData,
  output logic                  validWB,
  output logic [REG_ADDR_W-1:0] rdAddrWB,
  output logic                  rdWriteEnWB,
  output logic [1:0]            destinationSelectWB,
  output logic [XLEN-1:0]       pcWB,
  output logic [XLEN-1:0]       dmAddrWB,
  output logic [2:0]            loadStoreByteSelectWB,
  output logic [XLEN-1:0]       rdWriteDataWB,
  output logic                  misalignedWB
);

  typedef struct packed {
    memwb_ctrl_t           ctrl;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rd_data;
    logic [XLEN-1:0]       dm_addr;
  } memwb_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  memwb_t          mem_d;
  memwb_t          wb_q;
  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] load_data;
  logic            load_misaligned;
  logic            wb_is_load;

  always_comb begin
    mem_d.ctrl.valid    = validMEM;
    mem_d.ctrl.rd_we    = rdWriteEnMEM;
    mem_d.ctrl.dest_sel = wb_sel_e'(destinationSelectMEM);
    mem_d.ctrl.funct3   = loadStoreByteSelectMEM;
    mem_d.rd_addr       = rdAddrMEM;
    mem_d.pc            = pcMEM;
    mem_d.rd_data       = rdWriteDataMEM;
    mem_d.dm_addr       = dmAddrMEM;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q               <= '0;
      wb_q.ctrl.dest_sel <= WB_SEL_ALU;
    end else if (flushWB) begin
      // A bubble only needs valid and write-enable cleared.
      wb_q.ctrl.valid <= 1'b0;
      wb_q.ctrl.rd_we <= 1'b0;
    end else if (!stallWB) begin
      wb_q <= mem_d;
    end
  end

  assign wb_is_load = wb_q.ctrl.valid && (wb_q.ctrl.dest_sel == WB_SEL_LOAD);

  generate
    if (LOAD_HOLD_EN) begin : g_hold
      logic            held_q;
      logic [XLEN-1:0] hold_q;

      // Memory returns the load word only in the first WB cycle, so a stalled
      // load snapshots it once and replays it until the register moves on.
      always_ff @(posedge clk) begin
        if (rst) begin
          held_q <= 1'b0;
          hold_q <= '0;
        end else if (flushWB || !stallWB) begin
          held_q <= 1'b0;
        end else if (wb_is_load && !held_q) begin
          held_q <= 1'b1;
          hold_q <= dmLoadData;
        end
      end

      assign load_word = held_q ? hold_q : dmLoadData;
    end else begin : g_no_hold
      assign load_word = dmLoadData;
    end
  endgenerate

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .word       (load_word),
    .addr       (wb_q.dm_addr[1:0]),
    .funct3     (wb_q.ctrl.funct3),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  always_comb begin
    rdWriteDataWB = wb_q.rd_data;
    case (wb_q.ctrl.dest_sel)
      WB_SEL_LOAD: rdWriteDataWB = load_data;
      WB_SEL_PC4:  rdWriteDataWB = wb_q.pc + PC_STEP;
      default:     rdWriteDataWB = wb_q.rd_data;
    endcase
  end

  assign validWB               = wb_q.ctrl.valid;
  assign rdAddrWB              = wb_q.rd_addr;
  assign rdWriteEnWB           = wb_q.ctrl.rd_we & wb_q.ctrl.valid;
  assign destinationSelectWB   = wb_q.ctrl.dest_sel;
  assign pcWB                  = wb_q.pc;
  assign dmAddrWB              = wb_q.dm_addr;
  assign loadStoreByteSelectWB = wb_q.ctrl.funct3;
  assign misalignedWB          = wb_is_load & load_misaligned;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed corner cases plus random
// traffic compared against a behavioural model of the WB register.
module tb_mem_wb_stage;
  import loopyV_data_types::*;

  localparam int XLEN = 32;
  localparam int RA   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            validMEM = 1'b0;
  logic            stallWB = 1'b0;
  logic            flushWB = 1'b0;
  logic [RA-1:0]   rdAddrMEM = '0;
  logic            rdWriteEnMEM = 1'b0;
  logic [1:0]      destinationSelectMEM = 2'b00;
  logic [XLEN-1:0] pcMEM = '0;
  logic [XLEN-1:0] rdWriteDataMEM = '0;
  logic [XLEN-1:0] dmAddrMEM = '0;
  logic [2:0]      loadStoreByteSelectMEM = 3'b000;
  logic [XLEN-1:0] dmLoadData = '0;

  logic            validWB;
  logic [RA-1:0]   rdAddrWB;
  logic            rdWriteEnWB;
  logic [1:0]      destinationSelectWB;
  logic [XLEN-1:0] pcWB;
  logic [XLEN-1:0] dmAddrWB;
  logic [2:0]      loadStoreByteSelectWB;
  logic [XLEN-1:0] rdWriteDataWB;
  logic            misalignedWB;

  int n_vec  = 0;
  int n_miss = 0;

  mem_wb_stage #(
    .XLEN(XLEN), .REG_ADDR_W(RA), .LOAD_HOLD_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .validMEM(validMEM), .stallWB(stallWB), .flushWB(flushWB),
    .rdAddrMEM(rdAddrMEM), .rdWriteEnMEM(rdWriteEnMEM),
    .destinationSelectMEM(destinationSelectMEM), .pcMEM(pcMEM),
    .rdWriteDataMEM(rdWriteDataMEM), .dmAddrMEM(dmAddrMEM),
    .loadStoreByteSelectMEM(loadStoreByteSelectMEM), .dmLoadData(dmLoadData),
    .validWB(validWB), .rdAddrWB(rdAddrWB), .rdWriteEnWB(rdWriteEnWB),
    .destinationSelectWB(destinationSelectWB), .pcWB(pcWB), .dmAddrWB(dmAddrWB),
    .loadStoreByteSelectWB(loadStoreByteSelectWB), .rdWriteDataWB(rdWriteDataWB),
    .misalignedWB(misalignedWB)
  );

  always #5 clk = ~clk;

  // Behavioural model of what WB should hold; m_known drops after a flush or
  // reset, when the payload fields are not defined.
  logic            m_valid, m_we, m_known, m_held;
  logic [1:0]      m_sel;
  logic [RA-1:0]   m_rd;
  logic [2:0]      m_f3;
  logic [XLEN-1:0] m_pc, m_data, m_addr, m_hold;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_we = 1'b0; m_known = 1'b0; m_held = 1'b0;
      m_sel = WB_SEL_ALU; m_rd = '0; m_f3 = '0; m_pc = '0; m_addr = '0; m_hold = '0;
    end else if (flushWB) begin
      m_valid = 1'b0; m_we = 1'b0; m_known = 1'b0; m_held = 1'b0;
    end else if (stallWB) begin
      if (m_valid && m_sel == WB_SEL_LOAD && !m_held) begin
        m_hold = dmLoadData;
        m_held = 1'b1;
      end
    end else begin
      m_valid = validMEM; m_we = rdWriteEnMEM; m_sel = destinationSelectMEM;
      m_rd = rdAddrMEM; m_f3 = loadStoreByteSelectMEM; m_pc = pcMEM;
      m_data = rdWriteDataMEM; m_addr = dmAddrMEM; m_known = 1'b1; m_held = 1'b0;
    end
  end

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] bsh, hsh;
    bsh = w >> (8 * int'(a));
    hsh = w >> (16 * int'(a[1]));
    case (f3)
      3'b000:  return {{24{bsh[7]}}, bsh[7:0]};
      3'b100:  return {24'h0, bsh[7:0]};
      3'b001:  return {{16{hsh[15]}}, hsh[15:0]};
      3'b101:  return {16'h0, hsh[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    if (m_sel == WB_SEL_LOAD) return exp_load(m_held ? m_hold : dmLoadData, m_addr[1:0], m_f3);
    if (m_sel == WB_SEL_PC4)  return m_pc + 32'd4;
    return m_data;
  endfunction

  function automatic logic exp_mis();
    logic half_bad, word_bad;
    half_bad = (m_f3 == 3'b001 || m_f3 == 3'b101) && m_addr[0];
    word_bad = (m_f3 == 3'b010) && (m_addr[1:0] != 2'b00);
    return m_valid && (m_sel == WB_SEL_LOAD) && (half_bad || word_bad);
  endfunction

  task automatic drive_mem(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data,
                           input logic [XLEN-1:0] pc);
    validMEM = v; destinationSelectMEM = sel; loadStoreByteSelectMEM = f3;
    dmAddrMEM = addr; rdWriteDataMEM = data; pcMEM = pc;
    rdAddrMEM = 5'd7; rdWriteEnMEM = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_vec++;
    if ({validWB, rdAddrWB, rdWriteEnWB, destinationSelectWB, pcWB, dmAddrWB,
         loadStoreByteSelectWB, misalignedWB} !==
        {1'b0, 5'd0, 1'b0, WB_SEL_ALU, 32'd0, 32'd0, 3'd0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset: v=%b rd=%h we=%b sel=%b pc=%h addr=%h f3=%b mis=%b, required all zero",
               validWB, rdAddrWB, rdWriteEnWB, destinationSelectWB, pcWB, dmAddrWB,
               loadStoreByteSelectWB, misalignedWB);
    end
    rst = 1'b0;
  endtask

  task automatic test_lb();
    drive_mem(1'b1, WB_SEL_LOAD, 3'b000, 32'h0000_1003, 32'h0, 32'h40);
    step();
    dmLoadData = 32'h80FF_0000;
    #1;
    n_vec++;
    if ({rdWriteDataWB, misalignedWB, validWB, rdWriteEnWB} !== {32'hFFFF_FF80, 1'b0, 1'b1, 1'b1}) begin
      n_miss++;
      $display("FAIL lb: data=%h mis=%b v=%b we=%b, required ffffff80 0 1 1",
               rdWriteDataWB, misalignedWB, validWB, rdWriteEnWB);
    end
  endtask

  task automatic test_lh();
    drive_mem(1'b1, WB_SEL_LOAD, 3'b101, 32'h0000_2002, 32'h0, 32'h44);
    step();
    dmLoadData = 32'hBEEF_1234;
    #1;
    n_vec++;
    if ({rdWriteDataWB, misalignedWB} !== {32'h0000_BEEF, 1'b0}) begin
      n_miss++;
      $display("FAIL lhu: data=%h mis=%b, required 0000beef 0", rdWriteDataWB, misalignedWB);
    end
    drive_mem(1'b1, WB_SEL_LOAD, 3'b001, 32'h0000_2001, 32'h0, 32'h48);
    step();
    #1;
    n_vec++;
    if (misalignedWB !== 1'b1) begin
      n_miss++;
      $display("FAIL lh_misaligned: mis=%b, required 1", misalignedWB);
    end
  endtask

  task automatic test_load_hold();
    drive_mem(1'b1, WB_SEL_LOAD, 3'b010, 32'h0000_3000, 32'h0, 32'h100);
    stallWB = 1'b0;
    step();
    drive_mem(1'b1, WB_SEL_ALU, 3'b000, 32'h0, 32'h0000_DEAD, 32'h104);
    dmLoadData = 32'hCAFE_F00D;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) dmLoadData = 32'h0;
      stallWB = (c <= 3);
      #1;
      n_vec++;
      if ({rdWriteDataWB, validWB} !== {32'hCAFE_F00D, 1'b1}) begin
        n_miss++;
        $display("FAIL load_hold cycle %0d: data=%h v=%b, required cafef00d 1", c, rdWriteDataWB, validWB);
      end
      step();
    end
    #1;
    n_vec++;
    if (rdWriteDataWB !== 32'h0000_DEAD) begin
      n_miss++;
      $display("FAIL after_hold: data=%h, required 0000dead", rdWriteDataWB);
    end
  endtask

  task automatic test_pc4_wrap();
    drive_mem(1'b1, WB_SEL_PC4, 3'b000, 32'h0, 32'h5555_5555, 32'hFFFF_FFFC);
    step();
    #1;
    n_vec++;
    if ({rdWriteDataWB, pcWB} !== {32'h0, 32'hFFFF_FFFC}) begin
      n_miss++;
      $display("FAIL pc4_wrap: data=%h pc=%h, required 00000000 fffffffc", rdWriteDataWB, pcWB);
    end
  endtask

  task automatic test_flush_stall();
    drive_mem(1'b1, WB_SEL_ALU, 3'b000, 32'h0, 32'h77, 32'h200);
    flushWB = 1'b1;
    stallWB = 1'b1;
    step();
    flushWB = 1'b0;
    stallWB = 1'b0;
    #1;
    n_vec++;
    if ({validWB, rdWriteEnWB, misalignedWB} !== 3'b000) begin
      n_miss++;
      $display("FAIL flush_stall: v=%b we=%b mis=%b, required 0 0 0", validWB, rdWriteEnWB, misalignedWB);
    end
  endtask

  task automatic test_reset_mid_hold();
    drive_mem(1'b1, WB_SEL_LOAD, 3'b010, 32'h0000_4000, 32'h0, 32'h300);
    stallWB = 1'b0;
    step();
    stallWB = 1'b1;
    dmLoadData = 32'h1111_2222;
    step();
    rst = 1'b1;
    dmLoadData = 32'h0;
    step();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({validWB, rdAddrWB, rdWriteEnWB, destinationSelectWB, pcWB, dmAddrWB,
         loadStoreByteSelectWB, misalignedWB} !==
        {1'b0, 5'd0, 1'b0, WB_SEL_ALU, 32'd0, 32'd0, 3'd0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_mid_hold: v=%b rd=%h we=%b sel=%b pc=%h addr=%h f3=%b mis=%b, required all zero",
               validWB, rdAddrWB, rdWriteEnWB, destinationSelectWB, pcWB, dmAddrWB,
               loadStoreByteSelectWB, misalignedWB);
    end
    drive_mem(1'b1, WB_SEL_ALU, 3'b000, 32'h0, 32'h0000_1234, 32'h400);
    stallWB = 1'b0;
    step();
    #1;
    n_vec++;
    if ({validWB, rdWriteEnWB, rdWriteDataWB} !== {1'b1, 1'b1, 32'h0000_1234}) begin
      n_miss++;
      $display("FAIL post_reset_capture: v=%b we=%b data=%h, required 1 1 00001234",
               validWB, rdWriteEnWB, rdWriteDataWB);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_data;
    for (int i = 0; i < 600; i++) begin
      rst                    = ($urandom_range(0, 49) == 0);
      flushWB                = ($urandom_range(0, 9) == 0);
      stallWB                = ($urandom_range(0, 2) == 0);
      validMEM               = ($urandom_range(0, 3) != 0);
      rdWriteEnMEM           = $urandom_range(0, 1);
      rdAddrMEM              = RA'($urandom);
      destinationSelectMEM   = 2'($urandom);
      loadStoreByteSelectMEM = 3'($urandom);
      pcMEM                  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) pcMEM = 32'hFFFF_FFFC;
      rdWriteDataMEM         = $urandom;
      dmAddrMEM              = $urandom;
      dmLoadData             = $urandom;
      #1;
      n_vec++;
      if ({validWB, rdWriteEnWB, misalignedWB} !== {m_valid, m_we & m_valid, exp_mis()}) begin
        n_miss++;
        $display("FAIL rand_ctrl[%0d]: v/we/mis=%b%b%b, required %b%b%b", i,
                 validWB, rdWriteEnWB, misalignedWB, m_valid, m_we & m_valid, exp_mis());
      end
      if (m_known) begin
        e_data = exp_wdata();
        n_vec++;
        if ({rdAddrWB, destinationSelectWB, pcWB, dmAddrWB, loadStoreByteSelectWB, rdWriteDataWB} !==
            {m_rd, m_sel, m_pc, m_addr, m_f3, e_data}) begin
          n_miss++;
          $display("FAIL rand_data[%0d]: rd=%h sel=%b pc=%h addr=%h f3=%b data=%h, required %h %b %h %h %b %h",
                   i, rdAddrWB, destinationSelectWB, pcWB, dmAddrWB, loadStoreByteSelectWB,
                   rdWriteDataWB, m_rd, m_sel, m_pc, m_addr, m_f3, e_data);
        end
      end
      step();
    end
    rst = 1'b0;
    flushWB = 1'b0;
    stallWB = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lh();
    test_load_hold();
    test_pc4_wrap();
    test_flush_stall();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
